// File: rtl/lcd_frame_seq.sv
// rtl/lcd_frame_seq.sv - LCD PHY byte arbiter: host passthrough plus frame-mark triggered RAMWR + pixel burst
module lcd_frame_seq #(
    parameter int          FRAME_BYTES = 153600,
    parameter logic [7:0]  RAMWR_CMD   = 8'h2C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_data,
    input  logic       host_rs,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic       cfg_auto,
    input  logic       cfg_go,
    input  logic       cfg_abort,
    input  logic       fmark_stb,
    output logic [7:0] phy_data,
    output logic       phy_rs,
    output logic       phy_valid,
    input  logic       phy_ready,
    output logic       frame_busy,
    output logic       frame_done_stb,
    output logic       late_stb
);
    localparam int CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CMD, PIX} state_t;

    state_t        state, state_nx;
    logic          run;
    logic [CW-1:0] cnt;
    logic          fm_pend, abort_pend, done_q, late_q;
    logic          beat, host_pend, fm_hit, abort_req, abort_now;
    logic          cnt_load, cnt_dec, fm_clr, done_d;

    assign frame_busy     = (state == CMD) || (state == PIX);
    assign frame_done_stb = done_q;
    assign late_stb       = late_q;

    always_comb begin
        state_nx   = state;
        phy_valid  = 1'b0;
        phy_data   = 8'h00;
        phy_rs     = 1'b0;
        host_ready = 1'b0;
        pix_ready  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        fm_clr     = 1'b0;
        done_d     = 1'b0;
        host_pend  = host_valid & ~phy_ready;
        fm_hit     = fm_pend | fmark_stb;
        abort_req  = cfg_abort | abort_pend;

        // Output mux; everything stays quiet until the run flag is up.
        case (state)
            IDLE, ARMED: begin
                if (run) begin
                    phy_valid  = host_valid;
                    phy_data   = host_data;
                    phy_rs     = host_rs;
                    host_ready = phy_ready;
                end
            end
            CMD: begin
                phy_valid = run;
                phy_data  = RAMWR_CMD;
                phy_rs    = 1'b0;
            end
            PIX: begin
                phy_valid = run & pix_valid;
                phy_data  = pix_data;
                phy_rs    = 1'b1;
                pix_ready = run & phy_ready;
            end
            default: ;
        endcase

        beat      = phy_valid & phy_ready;
        abort_now = abort_req & (~phy_valid | beat);

        case (state)
            IDLE: begin
                if (!cfg_abort && (cfg_go || cfg_auto)) begin
                    state_nx = ARMED;
                    fm_clr   = 1'b1;
                end
            end
            ARMED: begin
                if (cfg_abort)
                    state_nx = IDLE;
                else if (fm_hit && !host_pend)
                    state_nx = CMD;
            end
            CMD: begin
                if (abort_now) begin
                    state_nx = IDLE;
                end else if (beat) begin
                    state_nx = PIX;
                    cnt_load = 1'b1;
                    fm_clr   = 1'b1;
                end
            end
            PIX: begin
                if (abort_now) begin
                    state_nx = IDLE;
                end else if (beat) begin
                    if (cnt == '0) begin
                        done_d   = 1'b1;
                        state_nx = cfg_auto ? ARMED : IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run        <= 1'b0;
            cnt        <= '0;
            fm_pend    <= 1'b0;
            abort_pend <= 1'b0;
            done_q     <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_nx;
            if (cnt_load)
                cnt <= CW'(FRAME_BYTES - 1);
            else if (cnt_dec)
                cnt <= cnt - 1'b1;
            if (fm_clr)
                fm_pend <= 1'b0;
            else if (state == ARMED && fmark_stb)
                fm_pend <= 1'b1;
            // An abort that could not be honoured this cycle waits for the next beat boundary.
            abort_pend <= abort_req && frame_busy && (state_nx == CMD || state_nx == PIX);
            done_q     <= done_d;
            late_q     <= fmark_stb && frame_busy;
        end
    end
endmodule

// File: tb/tb_lcd_frame_seq.sv
// tb/tb_lcd_frame_seq.sv - directed scoreboard bench for lcd_frame_seq
module tb_lcd_frame_seq;
    localparam int FB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_data;
    logic       host_rs, host_valid, host_ready;
    logic [7:0] pix_data;
    logic       pix_valid, pix_ready;
    logic       cfg_auto, cfg_go, cfg_abort, fmark_stb;
    logic [7:0] phy_data;
    logic       phy_rs, phy_valid, phy_ready;
    logic       frame_busy, frame_done_stb, late_stb;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_mem[256];
    int         obs_wr = 0;
    int         obs_rd = 0;
    int         done_cnt = 0, late_cnt = 0;
    int         stab_err = 0, busy_err = 0, pix_err = 0;
    logic       held = 1'b0;
    logic [8:0] held_v = '0;

    lcd_frame_seq #(.FRAME_BYTES(FB), .RAMWR_CMD(8'h2C)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_data(host_data), .host_rs(host_rs), .host_valid(host_valid), .host_ready(host_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cfg_auto(cfg_auto), .cfg_go(cfg_go), .cfg_abort(cfg_abort), .fmark_stb(fmark_stb),
        .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid), .phy_ready(phy_ready),
        .frame_busy(frame_busy), .frame_done_stb(frame_done_stb), .late_stb(late_stb)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so negedge values are what the next edge will see.
    always @(negedge clk) begin
        if (phy_valid && phy_ready) begin
            obs_mem[obs_wr[7:0]] = {phy_rs, phy_data};
            obs_wr = obs_wr + 1;
        end
        if (held && phy_valid && ({phy_rs, phy_data} !== held_v))
            stab_err = stab_err + 1;
        held   = rst_n && phy_valid && !phy_ready;
        held_v = {phy_rs, phy_data};
        if (frame_done_stb) done_cnt = done_cnt + 1;
        if (late_stb) late_cnt = late_cnt + 1;
        if (frame_busy && host_ready) busy_err = busy_err + 1;
        if (!frame_busy && pix_ready) pix_err = pix_err + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_byte(input logic rs, input logic [7:0] d);
        int budget;
        host_valid = 1'b1;
        host_rs    = rs;
        host_data  = d;
        exp_q.push_back({rs, d});
        budget = 0;
        while (!host_ready && budget < 50) begin
            step(1);
            budget++;
        end
        chk("host_wait", budget < 50, 1);
        step(1);
        host_valid = 1'b0;
    endtask

    task automatic pix_bytes(input logic [7:0] first, input int n);
        int budget;
        for (int i = 0; i < n; i++) begin
            pix_data  = first + 8'(i);
            pix_valid = 1'b1;
            exp_q.push_back({1'b1, pix_data});
            budget = 0;
            while (!pix_ready && budget < 50) begin
                step(1);
                budget++;
            end
            chk("pix_wait", budget < 50, 1);
            step(1);
        end
        pix_valid = 1'b0;
    endtask

    task automatic fmark(input logic expect_cmd);
        fmark_stb = 1'b1;
        if (expect_cmd) exp_q.push_back({1'b0, 8'h2C});
        step(1);
        fmark_stb = 1'b0;
    endtask

    task automatic check_beats(input string tag);
        int budget;
        logic [8:0] e;
        budget = 0;
        while ((obs_wr - obs_rd) < exp_q.size() && budget < 20) begin
            step(1);
            budget++;
        end
        chk({tag, "_count"}, obs_wr - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front();
            chk({tag, "_beat"}, obs_mem[obs_rd[7:0]], e);
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, frame_busy, 0);
        chk({tag, "_host_ready"}, host_ready, 1);
        chk({tag, "_pix_ready"}, pix_ready, 0);
    endtask

    initial begin
        int d0, l0;
        rst_n = 1'b0; phy_ready = 1'b1;
        host_valid = 1'b1; host_data = 8'hFF; host_rs = 1'b1;
        pix_valid = 1'b0; pix_data = 8'h00;
        cfg_auto = 1'b0; cfg_go = 1'b0; cfg_abort = 1'b0; fmark_stb = 1'b0;
        step(2);
        chk("rst_phy_valid", phy_valid, 0);
        chk("rst_phy_data", {phy_rs, phy_data}, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_busy_stb", {frame_busy, frame_done_stb, late_stb, pix_ready}, 0);
        rst_n = 1'b1;
        chk("run_gate_valid", phy_valid, 0);
        chk("run_gate_ready", host_ready, 0);
        host_valid = 1'b0;
        step(1);

        // host passthrough in IDLE
        host_byte(1'b0, 8'h11);
        host_byte(1'b1, 8'hA5);
        check_beats("host_idle");

        // single frame
        d0 = done_cnt;
        cfg_go = 1'b1; step(1); cfg_go = 1'b0;
        step(2);
        fmark(1'b1);
        pix_bytes(8'h01, FB);
        chk("f1_done_stb", frame_done_stb, 1);
        step(1);
        chk("f1_done_pulse", frame_done_stb, 0);
        chk("f1_done_cnt", done_cnt, d0 + 1);
        chk_idle("f1_idle");
        check_beats("frame1");

        // host byte held under backpressure while fmark arrives in ARMED
        cfg_go = 1'b1; step(1); cfg_go = 1'b0;
        host_valid = 1'b1; host_rs = 1'b0; host_data = 8'h36;
        exp_q.push_back({1'b0, 8'h36});
        phy_ready = 1'b0; fmark_stb = 1'b1;
        exp_q.push_back({1'b0, 8'h2C});
        step(1);
        fmark_stb = 1'b0;
        chk("hold_not_busy", frame_busy, 0);
        chk("hold_data", phy_data, 8'h36);
        phy_ready = 1'b1;
        step(1);
        host_valid = 1'b0;
        pix_bytes(8'h01, FB);
        chk("f2_done_stb", frame_done_stb, 1);
        step(1);
        check_beats("hold");

        // auto re-arm, stalled pixels, late frame mark
        d0 = done_cnt; l0 = late_cnt;
        cfg_auto = 1'b1; step(1);
        fmark(1'b1);
        pix_bytes(8'h01, 2);
        step(2);
        fmark_stb = 1'b1; step(1); fmark_stb = 1'b0;
        chk("late_stb", late_stb, 1);
        step(2);
        pix_bytes(8'h03, 2);
        step(3);
        chk("no_extra_frame", frame_busy, 0);
        cfg_auto = 1'b0;
        fmark(1'b1);
        pix_bytes(8'h01, FB);
        step(1);
        chk("auto_done_cnt", done_cnt, d0 + 2);
        chk("auto_late_cnt", late_cnt, l0 + 1);
        chk_idle("auto_idle");
        check_beats("auto");

        // abort after two pixel beats
        d0 = done_cnt;
        cfg_go = 1'b1; step(1); cfg_go = 1'b0;
        fmark(1'b1);
        pix_bytes(8'h01, 2);
        cfg_abort = 1'b1; step(1); cfg_abort = 1'b0;
        chk_idle("abort_idle");
        host_byte(1'b1, 8'h55);
        step(3);
        chk("abort_no_done", done_cnt, d0);
        cfg_go = 1'b1; step(1); cfg_go = 1'b0;
        fmark(1'b1);
        pix_bytes(8'h01, FB);
        step(1);
        chk("restart_done", done_cnt, d0 + 1);
        check_beats("abort");

        // reset mid-frame
        d0 = done_cnt;
        cfg_go = 1'b1; step(1); cfg_go = 1'b0;
        fmark(1'b1);
        pix_bytes(8'h01, 2);
        pix_valid = 1'b1; host_valid = 1'b1; host_rs = 1'b1; host_data = 8'h77;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", phy_valid, 0);
        chk("mid_rst_ready", {host_ready, pix_ready, frame_busy}, 0);
        step(2);
        rst_n = 1'b1;
        chk("rel_valid", phy_valid, 0);
        chk("rel_ready_stb", {host_ready, pix_ready, frame_done_stb, late_stb}, 0);
        exp_q.push_back({1'b1, 8'h77});
        step(1);
        chk("rel_host_pass", phy_valid, 1);
        chk_idle("rel_idle");
        step(1);
        host_valid = 1'b0; pix_valid = 1'b0;
        step(2);
        chk("rst_no_done", done_cnt, d0);
        check_beats("reset");

        chk("stable_hold", stab_err, 0);
        chk("host_locked", busy_err, 0);
        chk("pix_gated", pix_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lcd_frame_seq.md
Name: lcd_frame_seq

Overview:
- Sequencer and arbiter sitting directly in front of the LCD PHY's byte handshake (phy_data/phy_rs/phy_valid/phy_ready).
- Shares the PHY between a host command/data port (register/CPU side) and a pixel stream port (frame-buffer side).
- On an armed frame mark it issues a RAMWR command, then streams exactly FRAME_BYTES pixel bytes, locking the host out for the duration.
- Reports frame completion and late frames (frame mark arriving mid-frame).

Parameters:
FRAME_BYTES, 153600, pixel bytes per frame (320x240 RGB565); must be >= 1
RAMWR_CMD, 8'h2C, command byte issued with rs=0 before each frame

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
host_data  in  8  host byte
host_rs  in  1  host byte type (0 = cmd, 1 = data)
host_valid  in  1  host byte valid
host_ready  out  1  host byte accepted
pix_data  in  8  pixel byte
pix_valid  in  1  pixel byte valid
pix_ready  out  1  pixel byte accepted
cfg_auto  in  1  level; re-arm automatically after each frame
cfg_go  in  1  pulse; arm for one frame
cfg_abort  in  1  pulse; abandon armed/running frame
fmark_stb  in  1  one-cycle frame-mark strobe from PHY
phy_data  out  8  byte to PHY
phy_rs  out  1  byte type to PHY
phy_valid  out  1  byte valid to PHY
phy_ready  in  1  PHY ready
frame_busy  out  1  high in CMD or PIX
frame_done_stb  out  1  one-cycle pulse after last pixel byte accepted
late_stb  out  1  one-cycle pulse: fmark_stb seen while in CMD or PIX

Behaviour:
- Beat = cycle with phy_valid & phy_ready. The PHY handshake is combinational from state plus inputs: zero added latency.
- Reset (rst_n low): state IDLE, counter 0, fm_pend 0, run flag 0. phy_valid, host_ready, pix_ready, frame_busy and both strobes are 0. phy_data and phy_rs are 0.
- The run flag sets on the first clk edge after reset release. All valid/ready outputs stay gated low until it sets.
- States: IDLE, ARMED, CMD, PIX.
- IDLE:
  - Host passthrough: phy_* = host_*; host_ready = phy_ready; pix_ready = 0.
  - cfg_go or cfg_auto -> ARMED. fm_pend cleared.
- ARMED:
  - Host passthrough continues.
  - fmark_stb sets fm_pend.
  - Transition to CMD on the first cycle with fm_pend (or fmark_stb) and no pending host beat. A pending host beat is host_valid & ~phy_ready. This keeps phy_valid/data stable once presented.
  - cfg_abort -> IDLE.
- CMD:
  - phy_valid = 1, phy_data = RAMWR_CMD, phy_rs = 0. host_ready = 0, pix_ready = 0.
  - On beat -> PIX; counter loads FRAME_BYTES-1; fm_pend cleared.
- PIX:
  - phy_valid = pix_valid, phy_data = pix_data, phy_rs = 1. pix_ready = phy_ready; host_ready = 0.
  - Each beat decrements the counter.
  - Beat at counter == 0: frame_done_stb next cycle (registered). Next state is ARMED if cfg_auto, else IDLE.
  - pix_valid low simply stalls; no timeout.
- Abort: cfg_abort in CMD/PIX is honoured only at a beat boundary. This means the cycle where phy_valid is low, or the beat cycle itself. It then -> IDLE with no frame_done_stb. A pending abort is held in a flag until honoured.
- fmark_stb in CMD or PIX: late_stb next cycle; not queued, so no frame is started from it.
- Simultaneous events:
  - cfg_go with fmark_stb in IDLE: go to ARMED only; that fmark is not used.
  - cfg_abort with cfg_go: abort wins.
  - cfg_go in ARMED/CMD/PIX is ignored.
- Counter width = clog2(FRAME_BYTES) bits, minimum 1. No wrap: it is reloaded in CMD before use.
- frame_busy = state in {CMD, PIX}, combinational.
- rst_n assertion mid-frame returns to IDLE immediately. No completion pulse is generated.

Test Plan:
- FRAME_BYTES=4, phy_ready=1, host sends cmd 0x11 then data 0xA5 in IDLE -> PHY sees beats (0x11, rs0), (0xA5, rs1); pix_ready stays 0.
- cfg_go, fmark_stb 3 cycles later, pix bytes 01..04 always valid -> beats 2C/rs0, 01, 02, 03, 04/rs1; frame_done_stb one cycle after beat 04; state IDLE; host_ready=0 throughout frame.
- Host byte 0x36 presented in ARMED with phy_ready toggling 0,1 while fmark_stb arrives -> 0x36 accepted first, then 2C; phy_data never changes while phy_valid=1 and phy_ready=0.
- cfg_auto=1, two fmarks, pix_valid stalled 5 cycles mid-frame -> two complete frames (2C + 4 bytes each), two frame_done_stb; second fmark inside the stall yields late_stb and no extra 2C.
- cfg_abort after 2 pixel beats -> IDLE, no frame_done_stb, host passthrough restored next cycle; next cfg_go + fmark restarts with 2C and full 4 bytes.
- rst_n low for 2 cycles mid-PIX -> phy_valid, ready outputs and strobes 0 during reset and first cycle after release; state IDLE.
